// File: rtl/ws_key_pkg.sv
// Shared types for the keyboard matrix scanner: scan FSM states, the default
// key event record and the key-code width helper.
package ws_key_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_EVAL  = 1'b1
    } scan_state_t;

    // Default event layout, sized for the stock 11 x 4 matrix (44 keys).
    localparam int unsigned KEY_CODE_W_DEF = 6;

    // Field is named rel because release is a reserved word.
    typedef struct packed {
        logic [KEY_CODE_W_DEF-1:0] code;
        logic                      rel;
    } key_event_t;

    // Width of a key code col*ROWS+row for a cols x rows matrix.
    function automatic int unsigned key_code_w(input int unsigned cols, input int unsigned rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

endpackage

// File: rtl/ws_key_fifo.sv
// Small synchronous event queue. The head entry stays put until it is popped.
// A push into a full queue without a pop is dropped and flagged by drop.
module ws_key_fifo
    import ws_key_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = key_event_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty,
    output logic drop
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; a full queue can push while popping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ws_key_scanner.sv
// Keyboard matrix scanner: drives one column at a time, snapshots the
// synchronised rows, debounces every key and queues key events.
// Build option: WS_KEYSCAN_RELEASE_EN also queues release events.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_DRIVE | column driven, settle down-counter running; snapshot at 0
// ST_EVAL  | column still driven; debounce one row of the snapshot/cycle
module ws_key_scanner
    import ws_key_pkg::*;
#(
    parameter  int unsigned COLS           = 11,
    parameter  int unsigned ROWS           = 4,
    parameter  int unsigned SETTLE_CYCLES  = 8,
    parameter  int unsigned DEBOUNCE_SCANS = 3,
    parameter  int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned KW             = key_code_w(COLS, ROWS)
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic [COLS-1:0] col_drive_o,
    input  logic [ROWS-1:0] rows_n_in,
    output logic            key_valid_o,
    input  logic            key_ready_in,
    output logic [KW-1:0]   key_code_o,
    output logic            key_release_o,
    output logic            any_key_o,
    output logic            overflow_o
);
    localparam int unsigned NKEYS = COLS * ROWS;
    localparam int unsigned CW    = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned COLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROWW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SW    = $clog2(SETTLE_CYCLES);

    typedef struct packed {
        logic [KW-1:0] code;
        logic          rel;
    } evt_t;

    logic [ROWS-1:0]  rows_s1, rows_s2, rows, snap;
    scan_state_t      state, state_nxt;
    logic [COLW-1:0]  col, col_nxt;
    logic [ROWW-1:0]  row, row_nxt;
    logic [SW-1:0]    settle, settle_nxt;
    logic             snap_en;
    logic [NKEYS-1:0] stable;
    logic [CW-1:0]    cnt [NKEYS];
    logic [KW-1:0]    idx;
    logic             key_s;
    logic [CW-1:0]    key_c;
    logic             differs, fire, push;
    evt_t             push_evt, head_evt;
    logic             fifo_full, fifo_empty, fifo_drop;

    assign rows = ~rows_s2;
    assign idx  = KW'(int'(col) * int'(ROWS) + int'(row));

    // Two-flop synchroniser for the asynchronous row lines, plus the snapshot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rows_s1 <= '0;
            rows_s2 <= '0;
            snap    <= '0;
        end else begin
            rows_s1 <= rows_n_in;
            rows_s2 <= rows_s1;
            if (snap_en) begin
                snap <= rows;
            end
        end
    end

    // Scan state register; the column drive mirrors the next column.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_DRIVE;
            col         <= '0;
            row         <= '0;
            settle      <= SW'(SETTLE_CYCLES - 1);
            col_drive_o <= '0;
        end else begin
            state                <= state_nxt;
            col                  <= col_nxt;
            row                  <= row_nxt;
            settle               <= settle_nxt;
            col_drive_o          <= '0;
            col_drive_o[col_nxt] <= 1'b1;
        end
    end

    // Scan sequencing: settle count-down, then walk the rows, then next column.
    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        row_nxt    = row;
        settle_nxt = settle;
        snap_en    = 1'b0;
        case (state)
            ST_DRIVE: begin
                if (settle == '0) begin
                    snap_en   = 1'b1;
                    row_nxt   = '0;
                    state_nxt = ST_EVAL;
                end else begin
                    settle_nxt = settle - 1'b1;
                end
            end
            ST_EVAL: begin
                if (row == ROWW'(ROWS - 1)) begin
                    row_nxt    = '0;
                    settle_nxt = SW'(SETTLE_CYCLES - 1);
                    col_nxt    = (col == COLW'(COLS - 1)) ? '0 : col + 1'b1;
                    state_nxt  = ST_DRIVE;
                end else begin
                    row_nxt = row + 1'b1;
                end
            end
            default: state_nxt = ST_DRIVE;
        endcase
    end

    // Debounce decision for the key under evaluation this cycle.
    always_comb begin
        key_s   = stable[idx];
        key_c   = cnt[idx];
        differs = (state == ST_EVAL) && (snap[row] != key_s);
        fire    = differs && (key_c == CW'(DEBOUNCE_SCANS - 1));
    end

`ifdef WS_KEYSCAN_RELEASE_EN
    assign push = fire;
`else
    // Releases still update the debounced state but are never queued.
    assign push = fire && snap[row];
`endif

    assign push_evt.code = idx;
    assign push_evt.rel  = ~snap[row];

    // Per-key debounced state and disagreement counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stable <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                cnt[i] <= '0;
            end
        end else if (state == ST_EVAL) begin
            if (!differs) begin
                cnt[idx] <= '0;
            end else if (fire) begin
                stable[idx] <= snap[row];
                cnt[idx]    <= '0;
            end else begin
                cnt[idx] <= key_c + 1'b1;
            end
        end
    end

    ws_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data (push_evt),
        .pop       (key_valid_o && key_ready_in),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign key_valid_o   = !fifo_empty;
    assign key_code_o    = head_evt.code;
    assign key_release_o = head_evt.rel;

    // Registered status outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            any_key_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            any_key_o  <= |stable;
            overflow_o <= fifo_drop;
        end
    end

    drop_only_when_full: assert property (@(posedge clk_in) disable iff (rst_in) !fifo_drop || fifo_full);

endmodule

// File: tb/tb_ws_key_scanner.sv
// Directed bench for ws_key_scanner with an 11 x 4 key matrix model.
// Expected release behaviour follows WS_KEYSCAN_RELEASE_EN.
module tb_ws_key_scanner;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] col_drive_o;
    logic [3:0]  rows_n_in;
    logic        key_valid_o;
    logic        key_ready_in = 1'b0;
    logic [5:0]  key_code_o;
    logic        key_release_o;
    logic        any_key_o;
    logic        overflow_o;

    logic [43:0] keys = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    ws_key_scanner #(
        .COLS           (11),
        .ROWS           (4),
        .SETTLE_CYCLES  (8),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .col_drive_o   (col_drive_o),
        .rows_n_in     (rows_n_in),
        .key_valid_o   (key_valid_o),
        .key_ready_in  (key_ready_in),
        .key_code_o    (key_code_o),
        .key_release_o (key_release_o),
        .any_key_o     (any_key_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_in = ~clk_in;

    // Key matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows_n_in = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 11; c++) begin
                if (col_drive_o[c] && keys[c*4+r]) rows_n_in[r] = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
        cyc++;
    endtask

    // Reset is released on a negedge; that cycle is cycle 0.
    task automatic do_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_valid(input int max_cyc, output int at_cyc);
        while (!key_valid_o && cyc < max_cyc) step();
        at_cyc = key_valid_o ? cyc : -1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        keys = '0;
        key_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (col_drive_o !== 11'd0) begin errors++; $display("FAIL reset_col_drive got=%h exp=0", col_drive_o); end
        checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid_o); end
        checks++; if (key_code_o !== 6'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", key_code_o); end
        checks++; if (key_release_o !== 1'b0) begin errors++; $display("FAIL reset_release got=%b exp=0", key_release_o); end
        checks++; if (any_key_o !== 1'b0) begin errors++; $display("FAIL reset_any_key got=%b exp=0", any_key_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_idle_scan();
        logic [10:0] exp;
        do_reset();
        for (int k = 1; k <= 3 * 132; k++) begin
            step();
            exp = '0;
            exp[(cyc / 12) % 11] = 1'b1;
            checks++; if (col_drive_o !== exp) begin errors++; $display("FAIL scan_col_drive cyc=%0d got=%h exp=%h", cyc, col_drive_o, exp); end
            checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL scan_valid cyc=%0d got=%b exp=0", cyc, key_valid_o); end
            checks++; if (any_key_o !== 1'b0) begin errors++; $display("FAIL scan_any_key cyc=%0d got=%b exp=0", cyc, any_key_o); end
        end
    endtask

    // Key 14 (col 3, row 2) held from cycle 0: event in EVAL row 2 of col 3,
    // frame 2 -> cycle 2*132 + 3*12 + 8 + 2 = 310, visible at cycle 311.
    task automatic test_press_release();
        int at;
        logic seen;
        keys = '0;
        keys[14] = 1'b1;
        do_reset();
        checks++; if (any_key_o !== 1'b0) begin errors++; $display("FAIL press_any_key_early got=%b exp=0", any_key_o); end
        wait_valid(600, at);
        checks++; if (at !== 311) begin errors++; $display("FAIL press_valid_cycle got=%0d exp=311", at); end
        checks++; if (key_code_o !== 6'd14) begin errors++; $display("FAIL press_code got=%0d exp=14", key_code_o); end
        checks++; if (key_release_o !== 1'b0) begin errors++; $display("FAIL press_release got=%b exp=0", key_release_o); end
        while (cyc < 312) step();
        checks++; if (any_key_o !== 1'b1) begin errors++; $display("FAIL press_any_key got=%b exp=1", any_key_o); end
        key_ready_in = 1'b1;
        step();
        key_ready_in = 1'b0;
        checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL press_pop_valid got=%b exp=0", key_valid_o); end
        keys[14] = 1'b0;
`ifdef WS_KEYSCAN_RELEASE_EN
        wait_valid(cyc + 4 * 132, at);
        checks++; if (at < 0) begin errors++; $display("FAIL release_event got=none exp=event"); end
        checks++; if (key_code_o !== 6'd14) begin errors++; $display("FAIL release_code got=%0d exp=14", key_code_o); end
        checks++; if (key_release_o !== 1'b1) begin errors++; $display("FAIL release_flag got=%b exp=1", key_release_o); end
        key_ready_in = 1'b1;
        step();
        key_ready_in = 1'b0;
        repeat (4) step();
`else
        seen = 1'b0;
        repeat (4 * 132) begin
            step();
            if (key_valid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL release_no_event got=%b exp=0", seen); end
`endif
        checks++; if (any_key_o !== 1'b0) begin errors++; $display("FAIL release_any_key got=%b exp=0", any_key_o); end
    endtask

    // Key 5 pressed for exactly two frames: counter reaches 2 then clears.
    task automatic test_glitch();
        logic seen_v, seen_a;
        keys = '0;
        keys[5] = 1'b1;
        do_reset();
        seen_v = 1'b0;
        seen_a = 1'b0;
        while (cyc < 800) begin
            step();
            if (cyc == 264) keys[5] = 1'b0;
            if (key_valid_o) seen_v = 1'b1;
            if (any_key_o) seen_a = 1'b1;
        end
        checks++; if (seen_v !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", seen_v); end
        checks++; if (seen_a !== 1'b0) begin errors++; $display("FAIL glitch_any_key got=%b exp=0", seen_a); end
    endtask

    // Codes 0..3 push at cycles 272..275, code 4 at 284 is dropped -> pulse at 285.
    task automatic test_overflow();
        int first_v, ov_cnt, ov_cyc;
        keys = '0;
        keys[4:0] = 5'b11111;
        key_ready_in = 1'b0;
        do_reset();
        first_v = -1;
        ov_cnt = 0;
        ov_cyc = -1;
        while (cyc < 300) begin
            step();
            if (key_valid_o && first_v < 0) first_v = cyc;
            if (overflow_o) begin ov_cnt++; ov_cyc = cyc; end
            if (cyc == 280) begin
                checks++; if (key_code_o !== 6'd0) begin errors++; $display("FAIL ovf_head_hold got=%0d exp=0", key_code_o); end
            end
        end
        checks++; if (first_v !== 273) begin errors++; $display("FAIL ovf_first_valid got=%0d exp=273", first_v); end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovf_pulse_count got=%0d exp=1", ov_cnt); end
        checks++; if (ov_cyc !== 285) begin errors++; $display("FAIL ovf_pulse_cycle got=%0d exp=285", ov_cyc); end
        key_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (key_valid_o !== 1'b1 || key_code_o !== 6'(i)) begin
                errors++; $display("FAIL ovf_drain%0d got=v%b/%0d exp=v1/%0d", i, key_valid_o, key_code_o, i);
            end
            step();
        end
        key_ready_in = 1'b0;
        checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", key_valid_o); end
    endtask

    task automatic test_reset_midscan();
        int at;
        keys = '0;
        keys[14] = 1'b1;
        key_ready_in = 1'b0;
        do_reset();
        while (cyc < 320) step();
        checks++; if (key_valid_o !== 1'b1) begin errors++; $display("FAIL rst_mid_queued got=%b exp=1", key_valid_o); end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++; if (key_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_empty got=%b exp=0", key_valid_o); end
        checks++; if (any_key_o !== 1'b0) begin errors++; $display("FAIL rst_mid_any_key got=%b exp=0", any_key_o); end
        rst_in = 1'b0;
        cyc = 0;
        wait_valid(600, at);
        checks++; if (at !== 311) begin errors++; $display("FAIL rst_mid_reappear got=%0d exp=311", at); end
        checks++; if (key_code_o !== 6'd14 || key_release_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_event got=%0d/%b exp=14/0", key_code_o, key_release_o);
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_glitch();
        test_overflow();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws_key_scanner.md
# ws_key_scanner

Parametrised keyboard matrix scanner for the Woodstock calculator cores. It drives COLS open-drain column lines one at a time and samples ROWS active-low row inputs. Each key is debounced individually, and press events (optionally also release events) are queued in a small FIFO that the CPU keyboard interface reads with a valid/ready handshake. It replaces the fixed 11-column, split-row scan logic in the per-board tops. Board tops map their column and row pins onto its vectors.

## Interface
- COLS, 11, number of column lines
- ROWS, 4, number of row inputs per column
- SETTLE_CYCLES, 8, cycles a column is driven before its rows are snapshotted; must be ≥3
- DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to change a key's state; range 1..15
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2
- clk_in  in  1  system clock; the only clock
- rst_in  in  1  synchronous, active-high reset
- col_drive_o  out  COLS  1 = pull column low (top instantiates open-drain: 1→'0', 0→'Z')
- rows_n_in  in  ROWS  row lines, active low, externally pulled up, asynchronous
- key_valid_o  out  1  FIFO head holds an event
- key_ready_in  in  1  consumer accepts the head
- key_code_o  out  KW  col*ROWS+row, KW = clog2(COLS*ROWS)
- key_release_o  out  1  0 = press, 1 = release
- any_key_o  out  1  OR of all debounced key states
- overflow_o  out  1  one-cycle pulse when an event is dropped

## Operation
- rows_n_in passes through a two-flop synchroniser; the inverted output is `rows`.
- FSM states:
  - DRIVE: col_drive_o is one-hot at index `col`; count SETTLE_CYCLES cycles; on the last cycle, latch `rows` into `snap`; go to EVAL.
  - EVAL: col_drive_o is still asserted; evaluate row r = 0..ROWS-1, one row per cycle.
  - After row ROWS-1: col ← (col == COLS-1) ? 0 : col+1; go to DRIVE.
- Per-key evaluation (stable bit s, counter c):
  - snap[r] == s → c ← 0.
  - Otherwise c ← c+1. When c+1 == DEBOUNCE_SCANS: s ← snap[r], c ← 0, and an event {code, release = ~snap[r]} is generated.
- At most one event is generated per cycle, so simultaneous changes in one column enqueue in ascending row order.
- FIFO push: on any generated press event; release events only per Configuration.
- FIFO full and push without pop: event dropped, overflow_o pulses, FIFO contents unchanged.
- Full with simultaneous push and pop: both take effect, count unchanged.
- Transfer occurs when key_valid_o && key_ready_in. key_code_o and key_release_o are held stable while valid && !ready.
- any_key_o is registered from the OR of all s bits.
- Reset values:
  - col_drive_o = 0, key_valid_o = 0, key_code_o = 0, key_release_o = 0, any_key_o = 0, overflow_o = 0.
  - FIFO empty, all s and c bits = 0, col = 0, state DRIVE, synchroniser flops = 0.
- Reset mid-scan discards queued events and state. Keys held through reset are re-reported as presses after debounce.

## Timing
- Column period = SETTLE_CYCLES + ROWS cycles; frame = COLS × that period (default 12 / 132 cycles).
- SETTLE_CYCLES ≥3 covers synchroniser latency plus line settling.
- A level change that is stable from before a column's snapshot produces its event in that column's EVAL row cycle on the DEBOUNCE_SCANS-th frame.
- key_valid_o rises the cycle after the push.
- A glitch shorter than DEBOUNCE_SCANS frames produces no event.

## Configuration
- WS_KEYSCAN_RELEASE_EN defined: release events are pushed into the FIFO, with key_release_o = 1.
- Undefined: release events are not pushed; debounced state still updates, so key_release_o is constant 0 and any_key_o still falls on release.

## Structure
- Package ws_key_pkg:
  - scan state enum (DRIVE, EVAL)
  - event struct {code, release}
  - KW width helper function
- Sub-module ws_key_fifo: synchronous FIFO with parameter DEPTH and the event struct as payload. Outputs full/empty and a drop pulse on push-while-full; data is held stable while not popped.
- Debounce counters are a COLS×ROWS array of clog2(DEBOUNCE_SCANS+1)-bit counters inside the scanner.

## Test plan
- Reset, no keys pressed, 3 frames → col_drive_o cycles one-hot 0..10 every 12 cycles; key_valid_o stays 0; any_key_o stays 0.
- Hold col 3 / row 2 from cycle 0 → exactly one event: code 14, release 0, emitted in frame 3. any_key_o = 1 one cycle later.
- Row pulse lasting 2 frames (DEBOUNCE_SCANS = 3) → no event.
- key_ready_in held 0; 5 distinct keys pressed in col 0 rows 0–3 plus col 1 row 0 → codes 0, 1, 2, 3 queued in order; overflow_o pulses once for code 4; then ready = 1 drains 0, 1, 2, 3.
- Press and release code 14 with WS_KEYSCAN_RELEASE_EN defined → events (14, 0) then (14, 1). With the macro undefined → only (14, 0), and any_key_o returns to 0.
- Assert rst_in while key 14 is queued and held → FIFO empties immediately. After reset, the (14, 0) event reappears after DEBOUNCE_SCANS frames.
